// File: rtl/aa_tile_resolve.sv
// Auto-animation tile resolver: owns the mode-register speed/disable fields,
// snapshots the frame count per line and rewrites tile low bits into a 2-entry FIFO.
module aa_tile_resolve #(
  parameter int TILE_W = 20,
  parameter int ATTR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LSPC_WR,
  input  logic [15:0]       LSPC_WDATA,
  output logic [7:0]        AA_SPEED,
  output logic              AA_DISABLE,
  input  logic [2:0]        AA_COUNT,
  input  logic              LINE_START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [TILE_W-1:0] IN_TILE,
  input  logic [ATTR_W-1:0] IN_ATTR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [TILE_W-1:0] OUT_TILE,
  output logic [ATTR_W-1:0] OUT_ATTR
);

  localparam int DEPTH = 2;

  logic [7:0]        r_speed;
  logic              r_disable;
  logic [2:0]        r_snap;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_count;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [TILE_W-1:0] r_mem_tile [DEPTH];
  logic [ATTR_W-1:0] r_mem_attr [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_next;
  logic [TILE_W-1:0] w_res_tile;
  logic              w_unused_wdata;

  // Only speed and the disable bit are architecturally meaningful.
  assign w_unused_wdata = ^{LSPC_WDATA[7:4], LSPC_WDATA[2:0]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_speed   <= 8'd0;
      r_disable <= 1'b0;
    end else if (LSPC_WR) begin
      r_speed   <= LSPC_WDATA[15:8];
      r_disable <= LSPC_WDATA[3];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_snap <= 3'd0;
    end else if (LINE_START) begin
      r_snap <= AA_COUNT;
    end
  end

  // Resolution uses the registered snap/disable, so same-cycle updates
  // only affect later beats.
  always_comb begin
    w_res_tile = IN_TILE;
    if (!r_disable) begin
      if (IN_ATTR[3]) begin
        w_res_tile[2:0] = r_snap;
      end else if (IN_ATTR[2]) begin
        w_res_tile[1:0] = r_snap[1:0];
      end
    end
  end

  assign w_push = IN_VALID & r_in_ready;
  assign w_pop  = r_out_valid & OUT_READY;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count     <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_in_ready  <= (w_count_next < 2'd2);
      r_out_valid <= (w_count_next != 2'd0);
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_mem_tile[gi] <= '0;
          r_mem_attr[gi] <= '0;
        end else if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_mem_tile[gi] <= w_res_tile;
          r_mem_attr[gi] <= IN_ATTR;
        end
      end
    end
  endgenerate

  assign AA_SPEED   = r_speed;
  assign AA_DISABLE = r_disable;
  assign IN_READY   = r_in_ready;
  assign OUT_VALID  = r_out_valid;
  assign OUT_TILE   = r_mem_tile[r_rd_ptr];
  assign OUT_ATTR   = r_mem_attr[r_rd_ptr];

endmodule

// File: tb/tb_aa_tile_resolve.sv
// Directed plus randomized bench for aa_tile_resolve against a queue-based
// reference model of the resolve rules and FIFO ordering.
module tb_aa_tile_resolve;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LSPC_WR;
  logic [15:0] LSPC_WDATA;
  logic [7:0]  AA_SPEED;
  logic        AA_DISABLE;
  logic [2:0]  AA_COUNT;
  logic        LINE_START;
  logic        IN_VALID;
  logic        IN_READY;
  logic [19:0] IN_TILE;
  logic [7:0]  IN_ATTR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [19:0] OUT_TILE;
  logic [7:0]  OUT_ATTR;

  always #5 CLK = ~CLK;

  aa_tile_resolve #(.TILE_W(20), .ATTR_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .LSPC_WR(LSPC_WR), .LSPC_WDATA(LSPC_WDATA),
    .AA_SPEED(AA_SPEED), .AA_DISABLE(AA_DISABLE), .AA_COUNT(AA_COUNT),
    .LINE_START(LINE_START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_TILE(IN_TILE), .IN_ATTR(IN_ATTR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_TILE(OUT_TILE), .OUT_ATTR(OUT_ATTR)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic acc_last;

  // Reference state
  logic [27:0] q[$];
  logic [7:0]  m_speed;
  logic        m_dis;
  logic [2:0]  m_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_resolve(input logic [19:0] t, input logic [7:0] a);
    if (m_dis)    return t;
    if (a[3])     return (t & ~20'h7) | 20'(m_snap);
    if (a[2])     return (t & ~20'h3) | 20'(m_snap & 3'd3);
    return t;
  endfunction

  // One clock: called at negedge with inputs already driven.
  task automatic tick();
    logic [27:0] e;
    acc_last = 1'b0;
    if (OUT_VALID && OUT_READY) begin
      n_pops++;
      if (q.size() == 0) begin
        check("pop_from_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("pop_tile", 32'(OUT_TILE), 32'(e[27:8]));
        check("pop_attr", 32'(OUT_ATTR), 32'(e[7:0]));
      end
    end
    if (IN_VALID && IN_READY) begin
      q.push_back({model_resolve(IN_TILE, IN_ATTR), IN_ATTR});
      acc_last = 1'b1;
    end
    if (LSPC_WR) begin
      m_speed = LSPC_WDATA[15:8];
      m_dis   = LSPC_WDATA[3];
    end
    if (LINE_START) m_snap = AA_COUNT;
    @(posedge CLK);
    #1;
    check("in_ready", 32'(IN_READY), 32'(q.size() < 2));
    check("out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
    check("aa_speed", 32'(AA_SPEED), 32'(m_speed));
    check("aa_disable", 32'(AA_DISABLE), 32'(m_dis));
    if (q.size() > 0) begin
      e = q[0];
      check("head_tile", 32'(OUT_TILE), 32'(e[27:8]));
      check("head_attr", 32'(OUT_ATTR), 32'(e[7:0]));
    end
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) @(posedge CLK);
    q.delete();
    m_speed = 8'd0; m_dis = 1'b0; m_snap = 3'd0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic send_one(input logic [19:0] t, input logic [7:0] a, input logic [19:0] exp);
    IN_VALID = 1'b1; IN_TILE = t; IN_ATTR = a; OUT_READY = 1'b0;
    tick();
    IN_VALID = 1'b0;
    check("send_accept", 32'(acc_last), 32'd1);
    check("send_tile", 32'(OUT_TILE), 32'(exp));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pops0;
    RESET = 1'b1; LSPC_WR = 1'b0; LSPC_WDATA = 16'h0; AA_COUNT = 3'd0;
    LINE_START = 1'b0; IN_VALID = 1'b1; IN_TILE = 20'h55555; IN_ATTR = 8'h08;
    OUT_READY = 1'b0;
    @(negedge CLK);

    // Reset with a beat offered throughout
    do_reset(2);
    IN_VALID = 1'b0;
    tick();
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_speed", 32'(AA_SPEED), 32'h00);
    check("rst_disable", 32'(AA_DISABLE), 32'd0);
    check("rst_out_tile", 32'(OUT_TILE), 32'd0);
    check("rst_out_attr", 32'(OUT_ATTR), 32'd0);

    // Mode register write, disable set
    LSPC_WR = 1'b1; LSPC_WDATA = 16'hA508;
    tick();
    LSPC_WR = 1'b0;
    check("wr_speed", 32'(AA_SPEED), 32'hA5);
    check("wr_disable", 32'(AA_DISABLE), 32'd1);
    send_one(20'h12345, 8'h08, 20'h12345);

    // Enable, snapshot 5
    LSPC_WR = 1'b1; LSPC_WDATA = 16'h0000; AA_COUNT = 3'd5; LINE_START = 1'b1;
    tick();
    LSPC_WR = 1'b0; LINE_START = 1'b0;
    send_one(20'h0ABCF, 8'h08, 20'h0ABCD);
    send_one(20'h0ABCF, 8'h04, 20'h0ABCD);
    send_one(20'h0ABCF, 8'h0C, 20'h0ABCD);
    send_one(20'h0ABCF, 8'h00, 20'h0ABCF);

    // Mid-line count change, then pulse coincident with an accept
    AA_COUNT = 3'd2;
    send_one(20'h0ABCF, 8'h08, 20'h0ABCD);
    LINE_START = 1'b1;
    IN_VALID = 1'b1; IN_TILE = 20'h00000; IN_ATTR = 8'h08; OUT_READY = 1'b0;
    tick();
    LINE_START = 1'b0; IN_VALID = 1'b0;
    check("coincident_tile", 32'(OUT_TILE), 32'h00005);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    send_one(20'h00000, 8'h08, 20'h00002);

    // Backpressure: 6 beats, downstream stalled
    k = 0;
    OUT_READY = 1'b0;
    for (int c = 0; c < 8; c++) begin
      IN_VALID = 1'b1; IN_TILE = 20'h10000 + 20'(k); IN_ATTR = (k == 0) ? 8'h00 : 8'(k);
      tick();
      if (acc_last) k++;
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_in_ready", 32'(IN_READY), 32'd0);
    check("bp_hold_tile", 32'(OUT_TILE), 32'h10000);
    check("bp_hold_attr", 32'(OUT_ATTR), 32'h00);
    OUT_READY = 1'b1;
    pops0 = n_pops;
    for (int c = 0; c < 6; c++) begin
      IN_VALID = (k < 6); IN_TILE = 20'h10000 + 20'(k); IN_ATTR = 8'(k);
      tick();
      if (acc_last) k++;
    end
    IN_VALID = 1'b0;
    check("bp_all_accepted", 32'(k), 32'd6);
    check("bp_pops_per_cycle", 32'(n_pops - pops0), 32'd6);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Reset with the buffer full discards its contents
    OUT_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      IN_VALID = 1'b1; IN_TILE = 20'hFFFFF; IN_ATTR = 8'hFF;
      tick();
    end
    do_reset(1);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_out_tile", 32'(OUT_TILE), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      IN_VALID   = ($urandom_range(0, 3) != 0);
      IN_TILE    = 20'($urandom);
      IN_ATTR    = 8'($urandom);
      OUT_READY  = ($urandom_range(0, 2) != 0);
      AA_COUNT   = 3'($urandom);
      LINE_START = ($urandom_range(0, 15) == 0);
      LSPC_WR    = ($urandom_range(0, 31) == 0);
      LSPC_WDATA = 16'($urandom);
      tick();
    end
    IN_VALID = 1'b0; LINE_START = 1'b0; LSPC_WR = 1'b0; OUT_READY = 1'b1;
    for (int c = 0; c < 4 && q.size() > 0; c++) tick();
    check("final_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
